// File: rtl/mult_arbiter.sv
// Arbiter sharing one pipelined signed-by-unsigned multiplier among N requesters.
// Grants one operand pair per cycle and routes each product back to its issuer via a tag pipeline.
module mult_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned MUL_LAT = 1,
    parameter int unsigned PRIO0   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      iReq,
    input  logic [17*N-1:0]   iSignal,
    input  logic [16*N-1:0]   iCoef,
    output logic [N-1:0]      oGnt,
    output logic [16:0]       oMulA,
    output logic [15:0]       oMulB,
    input  logic [15:0]       iMulOut,
    output logic [15:0]       oResult,
    output logic [N-1:0]      oValid
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0]               ptr_q, ptr_d;
    logic [16:0]                 mul_a_q, mul_a_d;
    logic [15:0]                 mul_b_q, mul_b_d;
    logic [15:0]                 result_q, result_d;
    logic [N-1:0]                valid_q, valid_d;
    logic [MUL_LAT-1:0]          tag_v_q, tag_v_d;
    logic [MUL_LAT-1:0][PW-1:0]  tag_k_q, tag_k_d;

    logic                        gnt_any;
    logic                        prio_hit;
    logic [PW-1:0]               gnt_idx;
    logic [16:0]                 a_sel;
    logic [15:0]                 b_sel;
    int unsigned                 idx;

    // Arbitration: optional absolute priority for requester 0, else round-robin from ptr
    always_comb begin
        gnt_any  = 1'b0;
        prio_hit = 1'b0;
        gnt_idx  = '0;
        idx      = 0;
        if ((PRIO0 != 0) && iReq[0]) begin
            gnt_any  = 1'b1;
            prio_hit = 1'b1;
        end else begin
            for (int unsigned j = 0; j < N; j++) begin
                idx = 32'(ptr_q) + j;
                if (idx >= N) begin
                    idx = idx - N;
                end
                if (!gnt_any && iReq[PW'(idx)]) begin
                    gnt_any = 1'b1;
                    gnt_idx = PW'(idx);
                end
            end
        end
    end

    assign oGnt = gnt_any ? (N'(1) << gnt_idx) : '0;

    // Operand mux for the granted requester
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int k = 0; k < int'(N); k++) begin
            if (gnt_idx == PW'(k)) begin
                a_sel = iSignal[17*k +: 17];
                b_sel = iCoef[16*k +: 16];
            end
        end
    end

    always_comb begin
        ptr_d    = ptr_q;
        mul_a_d  = mul_a_q;
        mul_b_d  = mul_b_q;
        result_d = result_q;
        valid_d  = '0;
        tag_v_d  = '0;
        tag_k_d  = '0;

        if (gnt_any) begin
            mul_a_d = a_sel;
            mul_b_d = b_sel;
            if (!prio_hit) begin
                ptr_d = (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + PW'(1);
            end
        end

        // Tag shifts alongside the multiplier so the product finds its owner
        tag_v_d[0] = gnt_any;
        tag_k_d[0] = gnt_idx;
        for (int unsigned j = 1; j < MUL_LAT; j++) begin
            tag_v_d[j] = tag_v_q[j-1];
            tag_k_d[j] = tag_k_q[j-1];
        end

        if (tag_v_q[MUL_LAT-1]) begin
            result_d = iMulOut;
            valid_d  = N'(1) << tag_k_q[MUL_LAT-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q    <= '0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
            result_q <= '0;
            valid_q  <= '0;
            tag_v_q  <= '0;
            tag_k_q  <= '0;
        end else begin
            ptr_q    <= ptr_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            tag_v_q  <= tag_v_d;
            tag_k_q  <= tag_k_d;
        end
    end

    assign oMulA   = mul_a_q;
    assign oMulB   = mul_b_q;
    assign oResult = result_q;
    assign oValid  = valid_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: two instances (round-robin and requester-0 priority) sharing stimulus,
// each checked every cycle against a behavioural arbiter/product scoreboard, plus literal checks.
module tb_mult_arbiter;

    localparam int N  = 4;
    localparam int ML = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [N-1:0]      req;
    logic [17*N-1:0]   sig, sig_n;
    logic [16*N-1:0]   coef, coef_n;

    logic [N-1:0]  gnt0, gnt1, val0, val1;
    logic [16:0]   ma0, ma1;
    logic [15:0]   mb0, mb1, mo0, mo1, res0, res1;

    int total = 0;
    int bad   = 0;

    // Multiplier: (signed A * unsigned B) >> 16, saturated to 16 bits, one edge of latency
    function automatic logic [15:0] mulfn(input logic [16:0] a, input logic [15:0] b);
        longint sa, ub, p;
        sa = longint'($signed(a));
        ub = longint'({1'b0, b});
        p  = (sa * ub) >>> 16;
        if (p > 32767)  p = 32767;
        if (p < -32768) p = -32768;
        return p[15:0];
    endfunction

    assign mo0 = mulfn(ma0, mb0);
    assign mo1 = mulfn(ma1, mb1);

    mult_arbiter #(.N(N), .MUL_LAT(ML), .PRIO0(0)) dut_rr (
        .clk(clk), .rst(rst), .iReq(req), .iSignal(sig), .iCoef(coef),
        .oGnt(gnt0), .oMulA(ma0), .oMulB(mb0), .iMulOut(mo0),
        .oResult(res0), .oValid(val0)
    );

    mult_arbiter #(.N(N), .MUL_LAT(ML), .PRIO0(1)) dut_pr (
        .clk(clk), .rst(rst), .iReq(req), .iSignal(sig), .iCoef(coef),
        .oGnt(gnt1), .oMulA(ma1), .oMulB(mb1), .iMulOut(mo1),
        .oResult(res1), .oValid(val1)
    );

    task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] actual=%h required=%h t=%0t", nm, inst, act, exp, $time);
        end
    endtask

    // Reference: which requester the rules pick, -1 if none
    function automatic int pick(input logic [N-1:0] r, input int ptr, input bit prio);
        if (r == '0) return -1;
        if (prio && r[0]) return 0;
        for (int j = 0; j < N; j++) begin
            if (r[(ptr + j) % N]) return (ptr + j) % N;
        end
        return -1;
    endfunction

    int            cyc = 0;
    int            ptr_m [2];
    logic [16:0]   ma_m  [2];
    logic [15:0]   mb_m  [2];
    logic [15:0]   res_m [2];
    bit            pv    [2][8];
    int            pk    [2][8];
    logic [15:0]   pp    [2][8];

    // Scoreboard indexed by the cycle a product must appear on oValid/oResult
    task automatic model_cycle(input int i, input bit prio, input logic [N-1:0] g,
                               input logic [16:0] a, input logic [15:0] b,
                               input logic [15:0] r, input logic [N-1:0] v);
        int k, s, d;
        logic [N-1:0] ev;
        s  = cyc % 8;
        ev = '0;
        if (rst) begin
            ptr_m[i] = 0;
            ma_m[i]  = '0;
            mb_m[i]  = '0;
            res_m[i] = '0;
            for (int j = 0; j < 8; j++) pv[i][j] = 1'b0;
        end else if (pv[i][s]) begin
            ev       = N'(1) << pk[i][s];
            res_m[i] = pp[i][s];
            pv[i][s] = 1'b0;
        end
        chk("oMulA", i, 32'(a), 32'(ma_m[i]));
        chk("oMulB", i, 32'(b), 32'(mb_m[i]));
        chk("oResult", i, 32'(r), 32'(res_m[i]));
        chk("oValid", i, 32'(v), 32'(ev));
        k = pick(req, rst ? 0 : ptr_m[i], prio);
        chk("oGnt", i, 32'(g), (k < 0) ? 32'd0 : (32'd1 << k));
        if (!rst && k >= 0) begin
            ma_m[i]  = sig[17*k +: 17];
            mb_m[i]  = coef[16*k +: 16];
            d        = (cyc + ML + 1) % 8;
            pv[i][d] = 1'b1;
            pk[i][d] = k;
            pp[i][d] = mulfn(sig[17*k +: 17], coef[16*k +: 16]);
            if (!(prio && req[0])) ptr_m[i] = (k + 1) % N;
        end
    endtask

    always @(negedge clk) begin
        model_cycle(0, 1'b0, gnt0, ma0, mb0, res0, val0);
        model_cycle(1, 1'b1, gnt1, ma1, mb1, res1, val1);
        cyc++;
    end

    // One cycle: inputs change just after the edge, bench then waits for the sampling edge
    task automatic step(input logic r, input logic [N-1:0] q);
        @(posedge clk);
        #1;
        rst  = r;
        req  = q;
        sig  = sig_n;
        coef = coef_n;
        @(negedge clk);
    endtask

    int exp4 [6] = '{2, 4, 1, 2, 4, 1};

    initial begin
        rst = 1'b1; req = '0; sig = '0; coef = '0; sig_n = '0; coef_n = '0;
        repeat (2) step(1'b1, '0);

        // Single product: 0x4000 * 0x8000 >> 16 = 0x2000
        sig_n[16:0] = 17'h04000; coef_n[15:0] = 16'h8000;
        step(1'b0, 4'b0001);
        chk("t2 gnt", 0, 32'(gnt0), 32'h1);
        chk("t2 gnt", 1, 32'(gnt1), 32'h1);
        step(1'b0, '0);
        chk("t2 early valid", 0, 32'(val0), 32'h0);
        step(1'b0, '0);
        chk("t2 valid", 0, 32'(val0), 32'h1);
        chk("t2 result", 0, 32'(res0), 32'h2000);
        chk("t2 valid", 1, 32'(val1), 32'h1);
        chk("t2 result", 1, 32'(res1), 32'h2000);

        // Round-robin with all requesting
        step(1'b1, '0);
        for (int k = 0; k < N; k++) begin
            sig_n[17*k +: 17] = 17'(100 * (k + 1));
            coef_n[16*k +: 16] = 16'(16'h1000 * (k + 1));
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 4'b1111);
            chk("t3 rr gnt", 0, 32'(gnt0), 32'd1 << (i % 4));
            chk("t3 prio gnt", 1, 32'(gnt1), 32'h1);
        end

        // Priority override leaves the pointer alone
        step(1'b1, '0);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 4'b0110 | ((i == 2 || i == 5) ? 4'b0001 : 4'b0000));
            chk("t4 prio gnt", 1, 32'(gnt1), 32'(exp4[i]));
        end

        // Back-to-back grants to requester 2
        step(1'b0, '0);
        step(1'b0, '0);
        coef_n[32 +: 16] = 16'hFFFF;
        for (int i = 1; i <= 3; i++) begin
            sig_n[34 +: 17] = 17'(i);
            step(1'b0, 4'b0100);
            chk("t5 gnt", 0, 32'(gnt0), 32'h4);
        end
        chk("t5 valid a", 0, 32'(val0), 32'h4);
        chk("t5 result a", 0, 32'(res0), 32'h0);
        step(1'b0, '0);
        chk("t5 valid b", 0, 32'(val0), 32'h4);
        chk("t5 result b", 0, 32'(res0), 32'h1);
        step(1'b0, '0);
        chk("t5 valid c", 0, 32'(val0), 32'h4);
        chk("t5 result c", 0, 32'(res0), 32'h2);

        // Idle gap holds operands and result
        repeat (4) begin
            step(1'b0, '0);
            chk("t6 valid", 0, 32'(val0), 32'h0);
            chk("t6 result", 0, 32'(res0), 32'h2);
            chk("t6 mulA", 0, 32'(ma0), 32'h3);
            chk("t6 mulB", 0, 32'(mb0), 32'hFFFF);
        end

        // Reset with two products in flight
        step(1'b0, 4'b1111);
        step(1'b0, 4'b1111);
        step(1'b1, '0);
        chk("t1 valid", 0, 32'(val0), 32'h0);
        chk("t1 result", 0, 32'(res0), 32'h0);
        chk("t1 valid", 1, 32'(val1), 32'h0);
        chk("t1 result", 1, 32'(res1), 32'h0);
        repeat (3) begin
            step(1'b0, '0);
            chk("t1 stray valid", 0, 32'(val0), 32'h0);
            chk("t1 stray valid", 1, 32'(val1), 32'h0);
        end

        // Random traffic against the scoreboard
        for (int i = 0; i < 600; i++) begin
            for (int k = 0; k < N; k++) begin
                sig_n[17*k +: 17]  = 17'($urandom);
                coef_n[16*k +: 16] = 16'($urandom);
            end
            step(($urandom_range(0, 49) == 0), 4'($urandom));
        end
        repeat (4) step(1'b0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
